// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding and address geometry.
package inst_cache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REFILL    = 2'd1,
        ST_FILL_DONE = 2'd2
    } icache_state_t;

endpackage

// File: rtl/inst_cache_line_store.sv
// Valid/tag/data arrays for the direct-mapped instruction cache.
module icache_line_store
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 64,
    parameter int unsigned OFF_W      = $clog2(LINE_WORDS),
    parameter int unsigned IDX_W      = $clog2(LINES),
    parameter int unsigned TAG_W      = ADDR_W - 2 - OFF_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [OFF_W-1:0]  rd_offset,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [OFF_W-1:0]  wr_offset,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  tag_index,
    input  logic [TAG_W-1:0]  tag_data,
    input  logic              tag_valid
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [WORD_W-1:0] data_mem [LINES*LINE_WORDS];

    // Flush takes priority; the controller never requests a set in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[tag_index] <= tag_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[tag_index] <= tag_data;
        end
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
    end

    always_comb begin
        rd_valid = valid_q[rd_index];
        rd_tag   = tag_mem[rd_index];
        rd_data  = data_mem[{rd_index, rd_offset}];
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hits, word-by-word refill on miss.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    icache_state_t state_q, state_nxt;

    logic [TAG_W+IDX_W-1:0] line_q;
    logic [OFF_W-1:0]       cnt_q;
    logic [OFF_W-1:0]       cnt_nxt;
    logic                   flush_pending;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [TAG_W-1:0]  line_tag;
    logic [IDX_W-1:0]  line_idx;
    logic              unused_addr_bits;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data;

    logic              hit;
    logic              start_refill;
    logic              word_ack;
    logic              last_word;
    logic              tag_we;
    logic [IDX_W-1:0]  tag_index;
    logic [TAG_W-1:0]  tag_data;
    logic              tag_valid;

    assign req_tag          = inst_addr[31 -: TAG_W];
    assign req_idx          = inst_addr[2+OFF_W +: IDX_W];
    assign req_off          = inst_addr[2 +: OFF_W];
    assign unused_addr_bits = ^inst_addr[1:0];
    assign line_tag         = line_q[TAG_W+IDX_W-1:IDX_W];
    assign line_idx         = line_q[IDX_W-1:0];
    assign cnt_nxt          = cnt_q + 1'b1;

    icache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .LINES      (LINES),
        .OFF_W      (OFF_W),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .rd_index  (req_idx),
        .rd_offset (req_off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (word_ack),
        .wr_index  (line_idx),
        .wr_offset (cnt_q),
        .wr_data   (mem_data),
        .tag_we    (tag_we),
        .tag_index (tag_index),
        .tag_data  (tag_data),
        .tag_valid (tag_valid)
    );

    // A flush during refill must hide every line from the lookup in that same cycle.
    always_comb begin
        hit          = inst_ren & rd_valid & (rd_tag == req_tag)
                       & ~(flush & (state_q == ST_REFILL));
        stall        = rst ? 1'b0 : (inst_ren & ~hit);
        inst_data    = rst ? '0 : rd_data;
        start_refill = (state_q == ST_IDLE) & inst_ren & ~hit & ~flush;
        word_ack     = (state_q == ST_REFILL) & mem_ack;
        last_word    = word_ack & (cnt_q == '1);
        tag_we       = start_refill | (state_q == ST_FILL_DONE);
        tag_index    = start_refill ? req_idx : line_idx;
        tag_data     = start_refill ? req_tag : line_tag;
        tag_valid    = (state_q == ST_FILL_DONE) & ~flush_pending & ~flush;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:      if (start_refill) state_nxt = ST_REFILL;
            ST_REFILL:    if (last_word)    state_nxt = ST_FILL_DONE;
            ST_FILL_DONE: state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            line_q        <= '0;
            cnt_q         <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            flush_pending <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (start_refill) begin
                line_q   <= {req_tag, req_idx};
                cnt_q    <= '0;
                mem_req  <= 1'b1;
                mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                miss_cnt <= miss_cnt + 32'd1;
            end
            if ((state_q == ST_IDLE) && hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (word_ack) begin
                cnt_q <= cnt_nxt;
                if (last_word) begin
                    mem_req <= 1'b0;
                end else begin
                    mem_addr <= {line_q, cnt_nxt, 2'b00};
                end
            end
            if ((state_q == ST_REFILL) && flush) begin
                flush_pending <= 1'b1;
            end else if (state_q == ST_FILL_DONE) begin
                flush_pending <= 1'b0;
            end
        end
    end

endmodule
